// File: rtl/task_scheduler_if.sv
// Ingress-channel and RPU-issue signal bundle for task_scheduler.
// slave = scheduler view, master = driver/observer view.
interface task_scheduler_if #(
  parameter int PTW           = 16,
  parameter int LEVEL         = 4,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int PORTS         = 4,
  parameter int FIFO_DEPTH    = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [PORTS-1:0]                    i_push;
  logic [PORTS-1:0]                    i_pop;
  logic [PORTS-1:0][TREE_NUM_BITS-1:0] i_tree_id;
  logic [PORTS-1:0][PTW-1:0]           i_push_data;
  logic [PORTS-1:0]                    o_full;
  logic [PORTS-1:0][CW-1:0]            o_count;
  logic [LEVEL-1:0]                    i_rpu_ready;
  logic [LEVEL-1:0]                    o_rpu_push;
  logic [LEVEL-1:0]                    o_rpu_pop;
  logic [LEVEL-1:0][TREE_NUM_BITS-1:0] o_rpu_tree_id;
  logic [LEVEL-1:0][PTW-1:0]           o_rpu_push_data;
  logic [PORTS-1:0][15:0]              o_drop_cnt;

  modport slave (
    input  i_push, i_pop, i_tree_id, i_push_data, i_rpu_ready,
    output o_full, o_count, o_rpu_push, o_rpu_pop, o_rpu_tree_id, o_rpu_push_data, o_drop_cnt
  );

  modport master (
    output i_push, i_pop, i_tree_id, i_push_data, i_rpu_ready,
    input  o_full, o_count, o_rpu_push, o_rpu_pop, o_rpu_tree_id, o_rpu_push_data, o_drop_cnt
  );
endinterface

// File: rtl/task_scheduler.sv
// Per-channel task FIFOs + round-robin issue to ring RPUs; 2-cycle sample-to-issue latency,
// full channels drop new tasks, RPUs gate issue via i_rpu_ready and a per-RPU gap. Optional: TASK_SCHED_STATS_EN.
module ts_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_vld,
  input  logic [WIDTH-1:0]           i_wr_dat,
  output logic                       o_full,
  input  logic                       i_rd_rdy,
  output logic                       o_rd_vld,
  output logic [WIDTH-1:0]           o_rd_dat,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             w_wr;
  logic             w_rd;
  logic [CW-1:0]    w_count_nxt;

  // Space is judged on the registered full flag, so a dequeue never frees room for a same-cycle enqueue.
  assign w_wr = i_wr_vld && !r_full;
  assign w_rd = i_rd_rdy && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr && w_rd) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  assign o_full   = r_full;
  assign o_rd_vld = (r_count != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;
endmodule

module task_scheduler #(
  parameter int PTW           = 16,
  parameter int LEVEL         = 4,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int PORTS         = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int ISSUE_GAP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  task_scheduler_if.slave   bus
);
  localparam int TW = 2 + TREE_NUM_BITS + PTW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int LW = (LEVEL > 1) ? $clog2(LEVEL) : 1;
  localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

  logic [PORTS-1:0]                    w_enq_vld;
  logic [PORTS-1:0][TW-1:0]            w_enq_dat;
  logic [PORTS-1:0]                    w_full;
  logic [PORTS-1:0][CW-1:0]            w_count;
  logic [PORTS-1:0]                    w_deq;
  logic [PORTS-1:0]                    w_head_vld;
  logic [PORTS-1:0][TW-1:0]            w_head_dat;
  logic [PORTS-1:0][1:0]               w_head_op;
  logic [PORTS-1:0][TREE_NUM_BITS-1:0] w_head_tree;
  logic [PORTS-1:0][PTW-1:0]           w_head_data;
  logic [PORTS-1:0][LW-1:0]            w_head_tgt;

  logic [LEVEL-1:0]                    w_grant_vld;
  logic [LEVEL-1:0][PW-1:0]            w_grant_idx;
  logic [PW-1:0]                       w_cand;

  logic [LEVEL-1:0][PW-1:0]            r_rr_ptr;
  logic [LEVEL-1:0][GW-1:0]            r_gap_cnt;
  logic [LEVEL-1:0]                    r_rpu_push;
  logic [LEVEL-1:0]                    r_rpu_pop;
  logic [LEVEL-1:0][TREE_NUM_BITS-1:0] r_rpu_tree_id;
  logic [LEVEL-1:0][PTW-1:0]           r_rpu_push_data;

  // Entry layout {op, tree_id, data} with op[0]=push, op[1]=pop; both set is a PUSHPOP.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_enq_vld[p] = bus.i_push[p] | bus.i_pop[p];
      w_enq_dat[p] = {bus.i_pop[p], bus.i_push[p], bus.i_tree_id[p], bus.i_push_data[p]};
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_ch
    ts_fifo #(
      .WIDTH (TW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_wr_vld (w_enq_vld[p]),
      .i_wr_dat (w_enq_dat[p]),
      .o_full   (w_full[p]),
      .i_rd_rdy (w_deq[p]),
      .o_rd_vld (w_head_vld[p]),
      .o_rd_dat (w_head_dat[p]),
      .o_count  (w_count[p])
    );
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_head_op[p]   = w_head_dat[p][TW-1 -: 2];
      w_head_tree[p] = w_head_dat[p][PTW +: TREE_NUM_BITS];
      w_head_data[p] = w_head_dat[p][PTW-1:0];
      w_head_tgt[p]  = LW'(w_head_tree[p] & TREE_NUM_BITS'(LEVEL - 1));
    end
  end

  // A channel's head names a single RPU, so one channel can win at most one grant per cycle.
  always_comb begin
    w_grant_vld = '0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int r = 0; r < LEVEL; r++) begin
      if (bus.i_rpu_ready[r] && (r_gap_cnt[r] == '0)) begin
        for (int k = 0; k < PORTS; k++) begin
          w_cand = PW'((int'(r_rr_ptr[r]) + k) % PORTS);
          if (!w_grant_vld[r] && w_head_vld[w_cand] && (w_head_tgt[w_cand] == LW'(r))) begin
            w_grant_vld[r] = 1'b1;
            w_grant_idx[r] = w_cand;
          end
        end
      end
    end
  end

  always_comb begin
    w_deq = '0;
    for (int r = 0; r < LEVEL; r++) begin
      if (w_grant_vld[r]) w_deq[w_grant_idx[r]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr        <= '0;
      r_gap_cnt       <= '0;
      r_rpu_push      <= '0;
      r_rpu_pop       <= '0;
      r_rpu_tree_id   <= '0;
      r_rpu_push_data <= '1;
    end else begin
      for (int r = 0; r < LEVEL; r++) begin
        if (w_grant_vld[r]) begin
          r_rpu_push[r]      <= w_head_op[w_grant_idx[r]][0];
          r_rpu_pop[r]       <= w_head_op[w_grant_idx[r]][1];
          r_rpu_tree_id[r]   <= w_head_tree[w_grant_idx[r]];
          r_rpu_push_data[r] <= w_head_data[w_grant_idx[r]];
          r_gap_cnt[r]       <= GW'(ISSUE_GAP);
          r_rr_ptr[r]        <= (w_grant_idx[r] == PW'(PORTS - 1)) ? '0 : w_grant_idx[r] + PW'(1);
        end else begin
          r_rpu_push[r]      <= 1'b0;
          r_rpu_pop[r]       <= 1'b0;
          r_rpu_tree_id[r]   <= '0;
          r_rpu_push_data[r] <= '1;
          if (r_gap_cnt[r] != '0) r_gap_cnt[r] <= r_gap_cnt[r] - GW'(1);
        end
      end
    end
  end

`ifdef TASK_SCHED_STATS_EN
  logic [PORTS-1:0][15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (w_enq_vld[p] && w_full[p] && (r_drop_cnt[p] != 16'hFFFF)) begin
          r_drop_cnt[p] <= r_drop_cnt[p] + 16'd1;
        end
      end
    end
  end

  assign bus.o_drop_cnt = r_drop_cnt;
`else
  assign bus.o_drop_cnt = '0;
`endif

  assign bus.o_full          = w_full;
  assign bus.o_count         = w_count;
  assign bus.o_rpu_push      = r_rpu_push;
  assign bus.o_rpu_pop       = r_rpu_pop;
  assign bus.o_rpu_tree_id   = r_rpu_tree_id;
  assign bus.o_rpu_push_data = r_rpu_push_data;
endmodule

// File: doc/task_scheduler.md
# task_scheduler

Parametrised successor to the per-level task FIFO plus distributor front end of the SRAM PIFO tree. Accepts push, pop and combined push-pop tasks on PORTS ingress channels, buffers each channel in an internal FIFO, and issues tasks to the root RPU of the addressed tree (tree_id mod LEVEL). Issue is round-robin across channels, with a per-RPU issue gap that respects the SRAM read-modify-write pipeline. Sits between the tree's external push/pop ports and the RPU ring.

## Interface
- PTW, 16, payload width
- LEVEL, 4, number of RPUs/SRAMs in the ring (power of two)
- TREE_NUM, 4, number of virtual trees
- TREE_NUM_BITS, $clog2(TREE_NUM), tree id width
- PORTS, 4, ingress task channels
- FIFO_DEPTH, 8, entries per channel FIFO (power of two, ≥2)
- ISSUE_GAP, 2, minimum idle cycles on an RPU after an issue to it (0 = back-to-back)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_push  in  PORTS  per-channel push request
- i_pop  in  PORTS  per-channel pop request
- i_tree_id  in  TREE_NUM_BITS×PORTS  target tree per channel
- i_push_data  in  PTW×PORTS  push payload per channel
- o_full  out  PORTS  channel FIFO full (registered)
- o_count  out  ($clog2(FIFO_DEPTH)+1)×PORTS  channel occupancy
- i_rpu_ready  in  LEVEL  RPU can accept a new task this cycle
- o_rpu_push  out  LEVEL  one-cycle push issue
- o_rpu_pop  out  LEVEL  one-cycle pop issue
- o_rpu_tree_id  out  TREE_NUM_BITS×LEVEL  tree id of issued task
- o_rpu_push_data  out  PTW×LEVEL  payload of issued task
- o_drop_cnt  out  16×PORTS  dropped-task count (see Configuration)

## Operation
- Task encoding per entry: {op[1:0], tree_id, data}; op 01=PUSH, 10=POP, 11=PUSHPOP; 00 never stored.
- Enqueue: any of i_push/i_pop high on channel p forms a task. Both high forms PUSHPOP; these are not dropped.
- Enqueue is accepted iff o_count[p] < FIFO_DEPTH at the start of the cycle. A same-cycle dequeue does not free space for a same-cycle enqueue at full.
- Refused tasks are discarded; drop counter increments if enabled.
- Target RPU of a head task = tree_id & (LEVEL-1).
- RPU r is eligible when i_rpu_ready[r]=1 and gap_cnt[r]=0.
- Per eligible r, arbitration is over channels whose non-empty head targets r:
  - round-robin starting at rr_ptr[r];
  - the winner is dequeued;
  - rr_ptr[r] ← (winner+1) mod PORTS.
- Head-of-line blocking is strict per channel. A channel is granted at most once per cycle.
- On issue to r:
  - gap_cnt[r] ← ISSUE_GAP, then decrements by 1 per cycle, saturating at 0;
  - o_rpu_push[r] = op[0], o_rpu_pop[r] = op[1];
  - tree_id and data are driven with the issue.
- PUSHPOP asserts both o_rpu_push and o_rpu_pop in the same cycle.
- Idle RPU outputs: push/pop 0, tree_id 0, push_data all-ones.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width holds FIFO_DEPTH exactly.

## Timing
- Reset values, and state after rst high for one edge:
  - FIFOs empty, o_count=0, o_full=0;
  - rr_ptr=0, gap_cnt=0;
  - o_rpu_push/pop=0, o_rpu_tree_id=0, o_rpu_push_data=all-ones;
  - o_drop_cnt=0.
- Reset mid-operation discards all queued tasks and any pending gap. An issue registered on the reset edge is suppressed.
- Latency:
  - task sampled at edge N becomes head after edge N;
  - issue is decided in cycle N+1 and registered at edge N+1;
  - o_rpu_* are visible in cycle N+2, i.e. 2 cycles minimum.
- i_rpu_ready is sampled in the decide cycle. Issue outputs are registered pulses lasting exactly one cycle.
- With ISSUE_GAP=G, consecutive issues to the same RPU are at least G+1 cycles apart.
- o_full and o_count update at the edge following enqueue or dequeue.

## Configuration
- TASK_SCHED_STATS_EN defined:
  - o_drop_cnt[p] increments on each refused task;
  - saturates at 16'hFFFF;
  - cleared by rst.
- Undefined: no counter logic is generated and o_drop_cnt is tied to 0.

## Test plan
- Single push, port 0, tree 2, data 0x1234, all ready -> o_rpu_push[2]=1, tree_id 2, data 0x1234 exactly 2 cycles after sample; all other RPUs idle.
- Simultaneous i_push/i_pop port 1, tree 3 -> one PUSHPOP issue: o_rpu_push[3]=o_rpu_pop[3]=1 same cycle; o_count[1] returns to 0.
- Ports 0-3 all push tree 1 every cycle, ISSUE_GAP=2 -> RPU1 issues spaced 3 cycles apart, grant order 0,1,2,3,0; i_rpu_ready[1]=0 stalls issue with no loss.
- Fill port 0 to 8 with ready=0, push 3 more -> o_full[0]=1, o_count[0]=8, o_drop_cnt[0]=3 with TASK_SCHED_STATS_EN, else 0; release ready -> 8 tasks issued in FIFO order.
- Port 0 heads target RPU0 (blocked) and RPU1 queued behind -> no RPU1 issue until RPU0 head drains (HOL check).
- Assert rst with 5 queued tasks and gap_cnt nonzero -> next cycle all outputs at reset values; a subsequent push issues after 2 cycles.
